bist_controller: RTL and testbench

- Self-test responder for the scan-based BIST top: sits between the external `bist_start`/`bist_end`/`pass_fail` handshake and the circuit-under-test scan chain.
- On start:
  - generates pseudo-random scan patterns with an internal LFSR;
  - sequences shift/capture cycles;
  - compacts the chain response in a MISR;
  - compares the final signature with a golden value and reports pass/fail.

---
 rtl/bist_pkg.sv | 25 ++
 rtl/bist_misr.sv | 24 ++
 rtl/bist_controller.sv | 112 +++++++++++
 tb/tb_bist_controller.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// Shared types and constants for the scan BIST controller.
// Feedback helper covers both the pattern LFSR and the response MISR.
package bist_pkg;

    localparam int SIG_W = 16;
    localparam logic [SIG_W-1:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        CAPTURE,
        FLUSH,
        COMPARE,
        DONE
    } state_t;

    function automatic logic fb_bit(input logic [SIG_W-1:0] v);
        return ^(v & LFSR_TAPS);
    endfunction

    function automatic logic [SIG_W-1:0] lfsr_next(input logic [SIG_W-1:0] v);
        return {v[SIG_W-2:0], fb_bit(v)};
    endfunction

endpackage

// File: rtl/bist_misr.sv
// 16-bit multiple-input signature register compacting one serial stream.
// Synchronous clear has priority over the compaction enable.
module bist_misr
    import bist_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             din,
    output logic [SIG_W-1:0] sig
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= '0;
        end else if (clr) begin
            sig <= '0;
        end else if (en) begin
            sig <= {sig[SIG_W-2:0], fb_bit(sig) ^ din};
        end
    end

endmodule

// File: rtl/bist_controller.sv
// Scan BIST sequencer: LFSR patterns, shift/capture control, MISR compare.
// The first pattern's unload is discarded since the chain starts unknown.
module bist_controller
    import bist_pkg::*;
#(
    parameter int               SCAN_LEN   = 8,
    parameter int               N_PATTERNS = 100,
    parameter logic [SIG_W-1:0] LFSR_SEED  = 16'hACE1,
    parameter logic [SIG_W-1:0] GOLDEN_SIG = 16'h0000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             bist_start,
    input  logic             scan_out,
    output logic             scan_in,
    output logic             scan_en,
    output logic [SIG_W-1:0] signature,
    output logic             pass_fail,
    output logic             bist_end
);

    localparam int SH_W  = $clog2(SCAN_LEN) + 1;
    localparam int PAT_W = $clog2(N_PATTERNS) + 1;

    localparam logic [SH_W-1:0]  SH_LAST  = SH_W'(SCAN_LEN - 1);
    localparam logic [PAT_W-1:0] PAT_LAST = PAT_W'(N_PATTERNS - 1);

    state_t           state;
    logic [SH_W-1:0]  shift_cnt;
    logic [PAT_W-1:0] pat_cnt;
    logic [SIG_W-1:0] lfsr;
    logic             misr_en;
    logic             misr_clr;

    assign scan_in  = (state == SHIFT) && lfsr[SIG_W-1];
    assign misr_clr = (state == IDLE) && bist_start;
    assign misr_en  = ((state == SHIFT) && (pat_cnt != '0))
                   || (state == FLUSH);

    bist_misr u_misr (
        .clk   (CLK),
        .rst_n (RST),
        .en    (misr_en),
        .clr   (misr_clr),
        .din   (scan_out),
        .sig   (signature)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            scan_en   <= 1'b0;
            pass_fail <= 1'b0;
            bist_end  <= 1'b0;
            lfsr      <= LFSR_SEED;
            shift_cnt <= '0;
            pat_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bist_start) begin
                        lfsr      <= LFSR_SEED;
                        shift_cnt <= '0;
                        pat_cnt   <= '0;
                        scan_en   <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    lfsr <= lfsr_next(lfsr);
                    if (shift_cnt == SH_LAST) begin
                        shift_cnt <= '0;
                        scan_en   <= 1'b0;
                        state     <= CAPTURE;
                    end else begin
                        shift_cnt <= shift_cnt + SH_W'(1);
                    end
                end
                CAPTURE: begin
                    pat_cnt <= pat_cnt + PAT_W'(1);
                    scan_en <= 1'b1;
                    state   <= (pat_cnt < PAT_LAST) ? SHIFT : FLUSH;
                end
                FLUSH: begin
                    if (shift_cnt == SH_LAST) begin
                        shift_cnt <= '0;
                        scan_en   <= 1'b0;
                        state     <= COMPARE;
                    end else begin
                        shift_cnt <= shift_cnt + SH_W'(1);
                    end
                end
                COMPARE: begin
                    pass_fail <= (signature == GOLDEN_SIG);
                    bist_end  <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (!bist_start) begin
                        pass_fail <= 1'b0;
                        bist_end  <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bist_controller.sv
// Bench for bist_controller: tied and modelled scan chains checked against
// a pattern-level reference signature model.
module tb_bist_controller;

    localparam int          SL   = 8;
    localparam int          NP   = 100;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam int          LAT  = NP * (SL + 1) + SL + 1;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        bist_start = 1'b0;
    logic        scan_out;
    logic        scan_in;
    logic        scan_en;
    logic [15:0] signature;
    logic        pass_fail;
    logic        bist_end;

    int mode = 0;
    int n_chk = 0;
    int n_pass = 0;
    logic [7:0] chain;

    always #5 CLK = ~CLK;

    bist_controller #(
        .SCAN_LEN   (SL),
        .N_PATTERNS (NP),
        .LFSR_SEED  (SEED),
        .GOLDEN_SIG (16'h0000)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .bist_start (bist_start),
        .scan_out   (scan_out),
        .scan_in    (scan_in),
        .scan_en    (scan_en),
        .signature  (signature),
        .pass_fail  (pass_fail),
        .bist_end   (bist_end)
    );

    // Functional logic of the modelled CUT, applied on capture cycles.
    function automatic logic [7:0] cut_cap(input logic [7:0] c);
        return {c[6:0], c[7]} ^ 8'hA5 ^ {4'h0, c[7:4] & c[3:0]};
    endfunction

    always @(posedge CLK)
        chain <= (scan_en ? {chain[6:0], scan_in} : cut_cap(chain))
               & ((mode == 3) ? 8'hF7 : 8'hFF);

    assign scan_out = (mode == 0) ? 1'b0 :
                      (mode == 1) ? 1'b1 : chain[7];

    function automatic logic poly_fb(input logic [15:0] v);
        return v[15] ^ v[13] ^ v[12] ^ v[10];
    endfunction

    function automatic logic [7:0] stuck(input int md, input logic [7:0] c);
        logic [7:0] r;
        r = c;
        if (md == 3) r[3] = 1'b0;
        return r;
    endfunction

    function automatic logic ref_resp(input int md, input logic [7:0] c);
        if (md == 0) return 1'b0;
        if (md == 1) return 1'b1;
        return c[7];
    endfunction

    // Expected final signature for a full run in the given chain mode.
    function automatic logic [15:0] ref_sig(input int md);
        logic [15:0] l;
        logic [15:0] m;
        logic [7:0]  c;
        logic        o;
        l = SEED;
        m = 16'h0000;
        c = 8'h00;
        for (int p = 0; p < NP; p++) begin
            for (int i = 0; i < SL; i++) begin
                o = ref_resp(md, c);
                if (p > 0) m = {m[14:0], poly_fb(m) ^ o};
                c = stuck(md, {c[6:0], l[15]});
                l = {l[14:0], poly_fb(l)};
            end
            c = stuck(md, cut_cap(c));
        end
        for (int i = 0; i < SL; i++) begin
            o = ref_resp(md, c);
            m = {m[14:0], poly_fb(m) ^ o};
            c = stuck(md, {c[6:0], 1'b0});
        end
        return m;
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_scan_in"}, 32'(scan_in), 0);
        check({tag, "_scan_en"}, 32'(scan_en), 0);
        check({tag, "_sig"}, 32'(signature), 0);
        check({tag, "_pass"}, 32'(pass_fail), 0);
        check({tag, "_end"}, 32'(bist_end), 0);
    endtask

    // Raises bist_start (edge 0 is the next rising edge) and counts edges
    // until bist_end is seen; optionally toggles bist_start mid-run.
    task automatic run_bist(input bit toggle, output int lat);
        bist_start = 1'b1;
        @(posedge CLK);
        lat = 0;
        while (lat < LAT + 100) begin
            @(posedge CLK);
            lat++;
            #1;
            if (bist_end) break;
            if (toggle && lat < LAT - 20)
                bist_start = 1'($urandom_range(0, 1));
            else
                bist_start = 1'b1;
        end
        bist_start = 1'b1;
    endtask

    task automatic end_run();
        bist_start = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
    endtask

    initial begin
        int lat;
        int errs;
        logic [15:0] r1;
        logic [15:0] r2;
        logic [15:0] r3;

        r1 = ref_sig(1);
        r2 = ref_sig(2);
        r3 = ref_sig(3);

        repeat (3) @(posedge CLK);
        #1;
        check_zero("reset");
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);

        mode = 0;
        run_bist(1'b0, lat);
        check("t1_latency", 32'(lat), 32'(LAT));
        check("t1_sig", 32'(signature), 0);
        check("t1_pass", 32'(pass_fail), 1);

        errs = 0;
        repeat (50) begin
            @(posedge CLK);
            #1;
            if (!bist_end || scan_en || signature != 16'h0) errs++;
        end
        check("hold_done", 32'(errs), 0);
        bist_start = 1'b0;
        @(posedge CLK);
        #1;
        check("drop_end", 32'(bist_end), 0);
        check("drop_pass", 32'(pass_fail), 0);
        @(posedge CLK);
        #1;

        mode = 1;
        run_bist(1'b0, lat);
        check("t2_latency", 32'(lat), 32'(LAT));
        check("t2_sig", 32'(signature), 32'(r1));
        check("t2_sig_nz", 32'(signature != 16'h0), 1);
        check("t2_pass", 32'(pass_fail), 0);
        end_run();

        mode = 2;
        run_bist(1'b0, lat);
        check("t3_latency", 32'(lat), 32'(LAT));
        check("t3_sig", 32'(signature), 32'(r2));
        check("t3_pass", 32'(pass_fail), 32'(r2 == 16'h0));
        end_run();

        mode = 3;
        run_bist(1'b0, lat);
        check("t3f_sig", 32'(signature), 32'(r3));
        check("t3f_detect", 32'(signature != r2), 1);
        check("t3f_pass", 32'(pass_fail), 32'(r3 == 16'h0));
        end_run();

        mode = 1;
        bist_start = 1'b1;
        @(posedge CLK);
        repeat (400) @(posedge CLK);
        #2;
        RST = 1'b0;
        #1;
        check_zero("mid_reset");
        @(negedge CLK);
        RST = 1'b1;
        mode = 0;
        run_bist(1'b0, lat);
        check("t4_latency", 32'(lat), 32'(LAT));
        check("t4_sig", 32'(signature), 0);
        check("t4_pass", 32'(pass_fail), 1);
        end_run();

        mode = 1;
        run_bist(1'b1, lat);
        check("t6_latency", 32'(lat), 32'(LAT));
        check("t6_sig", 32'(signature), 32'(r1));
        check("t6_pass", 32'(pass_fail), 0);
        end_run();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
